tx_latency_tagger: RTL and testbench
====================================

Name: tx_latency_tagger

Overview:
- Sits directly upstream of the TX stream checker in the ASE CCI-P TX path.
- Accepts TX request headers and stamps each non-fence request with a monotonically increasing transaction ID.
- Holds each tagged request for an emulated latency (MIN_LAT..MAX_LAT cycles, LFSR-chosen), then releases it in order.
- Its input (valid_in/meta_in/tid_in) and output (valid_out/meta_out/tid_out) sides are the tap points the checker pairs up.

Parameters:
- DEPTH, 32, number of request entries; power of 2, >= 4.
- TID_WIDTH, 32, width of the transaction ID.
- MIN_LAT, 4, minimum hold in cycles; must be >= 1.
- MAX_LAT, 16, maximum hold in cycles; must be >= MIN_LAT.
- ALMFULL_THRESH, 4, almfull asserts when free entries <= this value.
- LFSR_SEED, 16'hACE1, reset value of the latency LFSR; must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  request present this cycle.
- meta_in  in  CCIP_TX_HDR_WIDTH  TxHdr_t request header.
- tid_in  out  TID_WIDTH  tag assigned to the current valid_in request.
- almfull  out  1  back-pressure hint to the upstream arbiter.
- full  out  1  count == DEPTH.
- valid_out  in/out: out  1  head request released.
- meta_out  out  CCIP_TX_HDR_WIDTH  head header.
- tid_out  out  TID_WIDTH  head tag.
- out_ready  in  1  downstream accepts the head.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset values:
  - valid_out, full, almfull and overflow are 0; count is 0.
  - tid counter is 0; LFSR is LFSR_SEED; cycle counter (32-bit, free-running) is 0.
  - meta_out and tid_out are 0 while valid_out is 0.
- tid_in:
  - Combinationally equals the current tid counter.
  - Meaningful only when valid_in is high and meta_in.reqtype != CCIP_WRFENCE.
- Accept rule:
  - A non-fence request is accepted when valid_in && !full; full is evaluated on the registered count.
  - A same-cycle pop does NOT free room for a push at full.
- On each accepted non-fence request:
  - Write {meta_in, tid counter, release_time} at the tail.
  - Increment the tid counter mod 2^TID_WIDTH (wraps silently).
  - Advance the LFSR one step: Galois form, taps x^16+x^14+x^13+x^11+1.
- release_time = now + MIN_LAT + (lfsr % (MAX_LAT-MIN_LAT+1)), where:
  - now is the cycle counter in the push cycle;
  - lfsr is the value before the advance.
  - 32-bit wraparound arithmetic.
- WRFENCE handling:
  - When valid_in with reqtype == CCIP_WRFENCE and !full: consumed, not stored, no tid consumed, LFSR not advanced, never appears on the output.
  - A fence when full is treated as overflow, same as a request.
- Overflow: valid_in while full sets overflow (sticky until rst); the request is dropped, the tid is not incremented and count is unchanged.
- Release:
  - valid_out = (count != 0) && ($signed(now - head.release_time) >= 0); wraparound-safe.
  - meta_out and tid_out drive the head entry combinationally.
- Pop: on valid_out && out_ready the head is retired and the read pointer advances.
  - If out_ready is low, valid_out, meta_out and tid_out hold stable.
- Strictly in order:
  - A later entry whose release_time has passed still waits behind an unreleased head (head-of-line blocking is intended).
  - tid_out is strictly sequential mod 2^TID_WIDTH.
- Latency: with the buffer empty and MIN_LAT == MAX_LAT == L, a request pushed in cycle N gives valid_out in cycle N+L. The entry is visible from N+1, so L = 1 gives N+1.
- Simultaneous push and pop (not full): both occur; count is unchanged.
- Pointers: ($clog2(DEPTH))-bit, wrap naturally.
- Flag updates:
  - full and almfull are derived from the registered count.
  - almfull = (DEPTH - count) <= ALMFULL_THRESH.
- Reset mid-operation: all entries are discarded (no output for them). The tid counter, LFSR, cycle counter and overflow return to their reset values the next cycle.

Test Plan:
- MIN_LAT = MAX_LAT = 4, single request pushed at cycle 10 -> tid_in = 0; valid_out at cycle 14 with tid_out = 0 and meta_out equal to the pushed header; count 1 -> 0 after the pop.
- Push 3 requests, then a WRFENCE, then 2 requests, out_ready = 1 -> exactly 5 outputs with tid_out 0,1,2,3,4; the fence is never output; the tid after the fence is 3.
- out_ready = 0 with DEPTH = 32: push 32 requests -> full = 1; almfull = 1 from count 28. A 33rd valid_in -> overflow = 1, count stays 32, next tid = 32. Assert out_ready -> tids 0..31 drain in order.
- MIN_LAT = 1, MAX_LAT = 16, 1000 random requests with random out_ready -> every tid delivered exactly once and in order. Each hold, measured from push to valid_out with the head free, lies in 1..16. Reference-model LFSR latencies match exactly.
- Preload the tid counter by pushing until it reaches 2^TID_WIDTH - 1 (TID_WIDTH = 4 variant) -> tids 15, 0, 1 are emitted consecutively.
- Assert rst for 1 cycle with 5 entries pending -> no valid_out afterwards; count = 0; the next push gets tid 0 and latency from LFSR_SEED.

Source files
------------

// File: rtl/tx_latency_tagger.sv
// ---------------------------------------------------------------------------
// tx_latency_tagger
//
// Purpose:
//   Sits in front of the TX stream checker. Every non-fence TX request header
//   is stamped with a monotonically increasing transaction ID. It is then held
//   for an emulated latency of MIN_LAT..MAX_LAT cycles, with the exact value
//   picked by a 16-bit Galois LFSR. Requests are released strictly in order.
//   Write fences are consumed without being stored or tagged.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   valid_in   in   request present this cycle
//   meta_in    in   TX request header (reqtype field at REQTYPE_LSB +: 4)
//   tid_in     out  tag given to the current valid_in request
//   almfull    out  back-pressure hint: free entries <= ALMFULL_THRESH
//   full       out  all DEPTH entries occupied
//   valid_out  out  head request released
//   meta_out   out  head header (0 while valid_out is low)
//   tid_out    out  head tag    (0 while valid_out is low)
//   out_ready  in   downstream accepts the head
//   count      out  occupied entries
//   overflow   out  sticky: a request arrived while full
// ---------------------------------------------------------------------------
module tx_latency_tagger #(
  parameter int          DEPTH             = 32,
  parameter int          TID_WIDTH         = 32,
  parameter int          MIN_LAT           = 4,
  parameter int          MAX_LAT           = 16,
  parameter int          ALMFULL_THRESH    = 4,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1,
  parameter int          CCIP_TX_HDR_WIDTH = 80,
  parameter int          REQTYPE_LSB       = 52,
  parameter logic [3:0]  CCIP_WRFENCE      = 4'h4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [CCIP_TX_HDR_WIDTH-1:0] meta_in,
  output logic [TID_WIDTH-1:0]         tid_in,
  output logic                         almfull,
  output logic                         full,
  output logic                         valid_out,
  output logic [CCIP_TX_HDR_WIDTH-1:0] meta_out,
  output logic [TID_WIDTH-1:0]         tid_out,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int LAT_SPAN = MAX_LAT - MIN_LAT + 1;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Entry storage, split into three arrays so each field is its own RAM
  logic [CCIP_TX_HDR_WIDTH-1:0] r_metaMem [DEPTH];
  logic [TID_WIDTH-1:0]         r_tidMem  [DEPTH];
  logic [31:0]                  r_relMem  [DEPTH];

  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [CW-1:0]        r_count;
  logic [TID_WIDTH-1:0] r_tidCtr;
  logic [15:0]          r_lfsr;
  logic [31:0]          r_now;
  logic                 r_overflow;

  logic        w_full;
  logic        w_isFence;
  logic        w_push;
  logic        w_pop;
  logic        w_headDue;
  logic        w_valid;
  logic [31:0] w_headAge;
  logic [31:0] w_latOff;
  logic [31:0] w_relTime;
  logic [31:0] w_free;
  logic [15:0] w_lfsrNext;

  // Flags come from the registered count only, so a pop in the same cycle
  // never makes room for a push while full.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_free    = 32'(DEPTH) - 32'(r_count);
  assign w_isFence = (meta_in[REQTYPE_LSB +: 4] == CCIP_WRFENCE);
  assign w_push    = valid_in && !w_full && !w_isFence;

  // The latency is drawn from the LFSR value before it advances.
  assign w_latOff  = 32'(r_lfsr) % 32'(LAT_SPAN);
  assign w_relTime = r_now + 32'(MIN_LAT) + w_latOff;

  assign w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

  // The head is due once the free-running cycle counter has reached its
  // release time. The sign bit of the difference keeps this correct across
  // 32-bit wraparound of the counter.
  assign w_headAge = r_now - r_relMem[r_rdPtr];
  assign w_headDue = !w_headAge[31];
  assign w_valid   = (r_count != '0) && w_headDue;
  assign w_pop     = w_valid && out_ready;

  assign tid_in    = r_tidCtr;
  assign full      = w_full;
  assign almfull   = (w_free <= 32'(ALMFULL_THRESH));
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign valid_out = w_valid;
  assign meta_out  = w_valid ? r_metaMem[r_rdPtr] : '0;
  assign tid_out   = w_valid ? r_tidMem[r_rdPtr]  : '0;

  // Entry storage is never reset; occupancy is tracked by the pointers and
  // count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_metaMem[r_wrPtr] <= meta_in;
      r_tidMem[r_wrPtr]  <= r_tidCtr;
      r_relMem[r_wrPtr]  <= w_relTime;
    end
  end

  // Pointers, occupancy, tag counter, LFSR, time base and the sticky
  // overflow flag. A reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_tidCtr   <= '0;
      r_lfsr     <= LFSR_SEED;
      r_now      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_now <= r_now + 32'd1;

      if (valid_in && w_full) begin
        r_overflow <= 1'b1;
      end

      if (w_push) begin
        r_wrPtr  <= r_wrPtr + AW'(1);
        r_tidCtr <= r_tidCtr + TID_WIDTH'(1);
        r_lfsr   <= w_lfsrNext;
      end

      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_latency_tagger.sv
// ---------------------------------------------------------------------------
// tb_tx_latency_tagger
//
// Purpose:
//   Self-checking bench for tx_latency_tagger. A transaction-level reference
//   model is kept in this module: a queue of {header, tag, release time}
//   plus a tag counter, an LFSR and a cycle count. It is compared against the
//   DUT every cycle. The run covers a fence sequence, fill-to-full with
//   overflow, a long randomized run that wraps the 8-bit tag, and a reset
//   with entries pending.
// ---------------------------------------------------------------------------
module tb_tx_latency_tagger;

  localparam int          DEPTH  = 32;
  localparam int          TW     = 8;
  localparam int          MINL   = 1;
  localparam int          MAXL   = 16;
  localparam int          SPAN   = MAXL - MINL + 1;
  localparam int          THRESH = 4;
  localparam int          HW     = 80;
  localparam int          RT_LSB = 52;
  localparam logic [3:0]  FENCE  = 4'h4;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int unsigned TMASK  = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [HW-1:0] meta_in;
  logic [TW-1:0] tid_in;
  logic          almfull;
  logic          full;
  logic          valid_out;
  logic [HW-1:0] meta_out;
  logic [TW-1:0] tid_out;
  logic          out_ready;
  logic [5:0]    count;
  logic          overflow;

  always #5 clk = ~clk;

  tx_latency_tagger #(
    .DEPTH(DEPTH), .TID_WIDTH(TW), .MIN_LAT(MINL), .MAX_LAT(MAXL),
    .ALMFULL_THRESH(THRESH), .LFSR_SEED(SEED), .CCIP_TX_HDR_WIDTH(HW),
    .REQTYPE_LSB(RT_LSB), .CCIP_WRFENCE(FENCE)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .meta_in(meta_in),
    .tid_in(tid_in), .almfull(almfull), .full(full), .valid_out(valid_out),
    .meta_out(meta_out), .tid_out(tid_out), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  typedef struct {
    logic [HW-1:0] meta;
    int unsigned   tid;
    int unsigned   rel;
  } entry_t;

  // Reference model state
  entry_t      q[$];
  int unsigned mNow;
  int unsigned mTid;
  logic [15:0] mLfsr;
  logic        mOvf;
  int unsigned nextOutTid;
  int          outSeen;
  int          nPushed;

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  // One step of the x^16+x^14+x^13+x^11+1 Galois LFSR
  function automatic logic [15:0] lfsrNext(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic bit modelDue();
    if (q.size() == 0) return 1'b0;
    return int'(mNow - q[0].rel) >= 0;
  endfunction

  function automatic logic [HW-1:0] randMeta(input bit isFence);
    logic [95:0]   raw;
    logic [HW-1:0] m;
    logic [3:0]    rt;
    raw = {$urandom, $urandom, $urandom};
    m   = raw[HW-1:0];
    rt  = m[RT_LSB +: 4];
    if (isFence)         rt = FENCE;
    else if (rt == FENCE) rt = rt ^ 4'h1;
    m[RT_LSB +: 4] = rt;
    return m;
  endfunction

  // Compare every DUT output with the model's current state
  task automatic checkAll();
    bit due;
    due = modelDue();
    checkOutput("valid_out", 128'(valid_out), 128'(due));
    checkOutput("count", 128'(count), 128'(q.size()));
    checkOutput("full", 128'(full), 128'(q.size() == DEPTH));
    checkOutput("almfull", 128'(almfull), 128'((DEPTH - q.size()) <= THRESH));
    checkOutput("overflow", 128'(overflow), 128'(mOvf));
    checkOutput("tid_in", 128'(tid_in), 128'(mTid));
    if (due) begin
      checkOutput("tid_out", 128'(tid_out), 128'(q[0].tid));
      checkOutput("meta_out", 128'(meta_out), 128'(q[0].meta));
    end else begin
      checkOutput("tid_out_idle", 128'(tid_out), 128'(0));
      checkOutput("meta_out_idle", 128'(meta_out), 128'(0));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming clock
  // edge, then check the DUT on the following falling edge.
  task automatic applyStimulus(input logic v, input logic [HW-1:0] m,
                               input logic rdy, input logic rs);
    bit pop;
    bit wasFull;
    valid_in  = v;
    meta_in   = m;
    out_ready = rdy;
    rst       = rs;
    if (!rs && valid_out === 1'b1 && rdy) begin
      checkOutput("orderTid", 128'(tid_out), 128'(nextOutTid));
      nextOutTid = (nextOutTid + 1) & TMASK;
      outSeen++;
    end
    if (rs) begin
      q.delete();
      mNow       = 0;
      mTid       = 0;
      mLfsr      = SEED;
      mOvf       = 1'b0;
      nextOutTid = 0;
      nPushed    = 0;
    end else begin
      pop     = modelDue() && rdy;
      wasFull = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (v) begin
        if (wasFull) begin
          mOvf = 1'b1;
        end else if (m[RT_LSB +: 4] != FENCE) begin
          q.push_back('{meta: m, tid: mTid,
                        rel: mNow + MINL + (int'(mLfsr) % SPAN)});
          mTid  = (mTid + 1) & TMASK;
          mLfsr = lfsrNext(mLfsr);
          nPushed++;
        end
      end
      mNow++;
    end
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    int base;
    int cyc;
    rst       = 1'b1;
    valid_in  = 1'b0;
    meta_in   = '0;
    out_ready = 1'b0;
    outSeen   = 0;
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("resetCount", 128'(count), 128'(0));
    checkOutput("resetValid", 128'(valid_out), 128'(0));

    // Three requests, a fence, two requests; all five come out, fence never
    base = outSeen;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randMeta(1'b0), 1'b1, 1'b0);
    applyStimulus(1'b1, randMeta(1'b1), 1'b1, 1'b0);
    checkOutput("tidAfterFence", 128'(tid_in), 128'(3));
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, randMeta(1'b0), 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("fenceOutCount", 128'(outSeen - base), 128'(5));

    // Fill to full with the output stalled, overflow once, then drain
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randMeta(1'b0), 1'b0, 1'b0);
    checkOutput("fullAtDepth", 128'(full), 128'(1));
    checkOutput("almfullAtDepth", 128'(almfull), 128'(1));
    applyStimulus(1'b1, randMeta(1'b0), 1'b0, 1'b0);
    checkOutput("overflowSet", 128'(overflow), 128'(1));
    checkOutput("countHeld", 128'(count), 128'(DEPTH));
    checkOutput("tidAfterOvf", 128'(tid_in), 128'(DEPTH));
    base = outSeen;
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drainCount", 128'(outSeen - base), 128'(DEPTH));
    checkOutput("overflowSticky", 128'(overflow), 128'(1));

    // Randomized run: 1000 requests with random fences and back-pressure
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    cyc = 0;
    while (nPushed < 1000 && cyc < 20000) begin
      applyStimulus(($urandom % 4) != 0, randMeta(($urandom % 10) == 0),
                    ($urandom % 3) != 0, 1'b0);
      cyc++;
    end
    checkOutput("randPushBudget", 128'(nPushed), 128'(1000));
    cyc = 0;
    while (q.size() != 0 && cyc < 400) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      cyc++;
    end
    checkOutput("randDrained", 128'(count), 128'(0));
    checkOutput("randAllDelivered", 128'(nextOutTid), 128'(1000 & TMASK));

    // Reset with five entries pending
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randMeta(1'b0), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("countAfterRst", 128'(count), 128'(0));
    checkOutput("validAfterRst", 128'(valid_out), 128'(0));
    checkOutput("tidAfterRst", 128'(tid_in), 128'(0));
    // Seed 0xACE1 % 16 = 1, so the first hold is MIN_LAT + 1 = 2 cycles
    applyStimulus(1'b1, randMeta(1'b0), 1'b0, 1'b0);
    checkOutput("seedLatEarly", 128'(valid_out), 128'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("seedLatDue", 128'(valid_out), 128'(1));
    checkOutput("seedLatTid", 128'(tid_out), 128'(0));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("finalEmpty", 128'(count), 128'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
